// File: rtl/inst_issuer_pkg.sv
// Shared instruction types and the issuer FSM state encoding.
package inst_issuer_pkg;

   typedef logic [5:0]  t_opcode;
   typedef logic [15:0] t_data;
   typedef logic [4:0]  t_reg_name;

   typedef struct packed {
      t_opcode   opcode;
      t_data     imm;
      t_reg_name src1;
      t_reg_name src2;
      t_reg_name dst;
   } t_inst;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, RSTP} t_issue_state;

endpackage

// File: rtl/issuer_fifo.sv
// Instruction buffer: power-of-two circular FIFO with occupancy count.
module issuer_fifo
   import inst_issuer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
)(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  t_inst                         push_data,
   input  logic                          pop,
   output t_inst                         pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr;
   t_inst         mem [FIFO_DEPTH];
   logic          do_push, do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // NOTE: storage has no reset; the count alone decides which entries are valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: all state updates use <= so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_issuer.sv
// Drains the instruction buffer onto the machine bus with optional idle gaps,
// halt, and a machine-reset pulse generator.
module inst_issuer
   import inst_issuer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int RST_CYCLES = 2,
   parameter int GAP_W      = 4
)(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         host_valid,
   output logic                         host_ready,
   input  t_opcode                      host_opcode,
   input  t_data                        host_imm,
   input  t_reg_name                    host_src1,
   input  t_reg_name                    host_src2,
   input  t_reg_name                    host_dst,
   input  logic [GAP_W-1:0]             gap,
   input  logic                         halt,
   input  logic                         mc_rst_req,
   output logic                         mc_reset,
   output logic                         instv,
   output t_opcode                      opcode,
   output t_data                        imm,
   output t_reg_name                    src1,
   output t_reg_name                    src2,
   output t_reg_name                    dst,
   output logic [$clog2(FIFO_DEPTH):0]  count,
   output logic                         busy
);

   localparam int CW = $clog2(FIFO_DEPTH);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   logic             rst_meta, rst_n_sync;
   t_issue_state     state, next_state;
   logic [GAP_W-1:0] gap_cnt;
   logic [RW-1:0]    rst_cnt;
   logic             push, pop, fire, more_ready;
   logic             fifo_full, fifo_empty;
   t_inst            push_data, head;

   // Assertion reaches every flop at once; release is retimed to the clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) {rst_meta, rst_n_sync} <= 2'b00;
      else        {rst_meta, rst_n_sync} <= {1'b1, rst_meta};
   end

   assign push_data  = '{opcode: host_opcode, imm: host_imm, src1: host_src1,
                         src2: host_src2, dst: host_dst};
   assign host_ready = !fifo_full;
   assign push       = host_valid && host_ready;
   assign pop        = (state == ISSUE) && !fifo_empty;
   assign fire       = pop && !mc_rst_req;
   // After this cycle's pop, is another entry (old or arriving) available?
   assign more_ready = !halt && ((count > (CW+1)'(1)) || push);

   issuer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (rst_n_sync),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync) state <= IDLE;
      else             state <= next_state;
   end

   // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:  if (count != '0 && !halt) next_state = ISSUE;
         ISSUE: if (gap != '0)            next_state = GAP;
                else if (more_ready)      next_state = ISSUE;
                else                      next_state = IDLE;
         GAP:   if (gap_cnt <= GAP_W'(1))
                   next_state = (count != '0 && !halt) ? ISSUE : IDLE;
         RSTP:  if (rst_cnt == '0)        next_state = IDLE;
      endcase
      if (mc_rst_req) next_state = RSTP;
   end

   always_comb begin
      mc_reset = (state == RSTP);
      busy     = (state != IDLE) || (count != '0);
   end

   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         gap_cnt <= '0;
         rst_cnt <= '0;
      end else begin
         if (state == RSTP)                     gap_cnt <= '0;
         else if (state == ISSUE)               gap_cnt <= gap;
         else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);

         if (mc_rst_req)                          rst_cnt <= RW'(RST_CYCLES - 1);
         else if (state == RSTP && rst_cnt != '0) rst_cnt <= rst_cnt - RW'(1);
      end
   end

   // Fields only load on a real issue, so they hold the last instruction otherwise.
   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         instv  <= 1'b0;
         opcode <= '0;
         imm    <= '0;
         src1   <= '0;
         src2   <= '0;
         dst    <= '0;
      end else begin
         instv <= fire;
         if (fire) begin
            opcode <= head.opcode;
            imm    <= head.imm;
            src1   <= head.src1;
            src2   <= head.src2;
            dst    <= head.dst;
         end
      end
   end

endmodule

// File: tb/tb_inst_issuer.sv
// Directed self-checking bench for inst_issuer.
module tb_inst_issuer;
   import inst_issuer_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       host_valid = 1'b0;
   logic       host_ready;
   t_opcode    host_opcode = '0;
   t_data      host_imm = '0;
   t_reg_name  host_src1 = '0, host_src2 = '0, host_dst = '0;
   logic [3:0] gap = '0;
   logic       halt = 1'b0;
   logic       mc_rst_req = 1'b0;
   logic       mc_reset, instv, busy;
   t_opcode    opcode;
   t_data      imm;
   t_reg_name  src1, src2, dst;
   logic [3:0] count;

   int total = 0;
   int bad   = 0;

   inst_issuer #(.FIFO_DEPTH(8), .RST_CYCLES(2), .GAP_W(4)) dut (
      .clock(clock), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
      .host_opcode(host_opcode), .host_imm(host_imm), .host_src1(host_src1),
      .host_src2(host_src2), .host_dst(host_dst), .gap(gap), .halt(halt),
      .mc_rst_req(mc_rst_req), .mc_reset(mc_reset), .instv(instv), .opcode(opcode),
      .imm(imm), .src1(src1), .src2(src2), .dst(dst), .count(count), .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entry n carries opcode n, imm A000+n and register names n, n+1, n+2.
   task automatic set_entry(input int n);
      host_opcode = t_opcode'(n);
      host_imm    = t_data'(32'hA000 + n);
      host_src1   = t_reg_name'(n);
      host_src2   = t_reg_name'(n + 1);
      host_dst    = t_reg_name'(n + 2);
   endtask

   task automatic check_issue(input string tag, input int n);
      check({tag, "_instv"}, instv, 1);
      check({tag, "_op"}, opcode, n);
      check({tag, "_imm"}, imm, 32'hA000 + n);
      check({tag, "_dst"}, dst, (n + 2) % 32);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_instv", instv, 0);
      check("rst_op", opcode, 0);
      check("rst_mcreset", mc_reset, 0);
      check("rst_ready", host_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      reset = 1'b1;
      repeat (3) tick();

      // A, B, C back to back, gap 0
      set_entry(1); host_valid = 1'b1;
      tick();
      check("abc_count_k", count, 1);
      check("abc_instv_k", instv, 0);
      set_entry(2);
      tick();
      check("abc_instv_k1", instv, 0);
      set_entry(3);
      tick();
      check_issue("abc_a", 1);
      host_valid = 1'b0;
      tick();
      check_issue("abc_b", 2);
      tick();
      check_issue("abc_c", 3);
      tick();
      check("abc_idle_instv", instv, 0);
      check("abc_hold_op", opcode, 3);
      check("abc_busy", busy, 0);

      // gap = 3 between two issues
      gap = 4'd3;
      set_entry(4); host_valid = 1'b1;
      tick();
      set_entry(5);
      tick();
      host_valid = 1'b0;
      tick();
      check_issue("gap_d", 4);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("gap_idle%0d", i), instv, 0);
         check($sformatf("gap_hold%0d", i), opcode, 4);
      end
      tick();
      check_issue("gap_e", 5);
      gap = 4'd0;
      repeat (4) tick();
      check("gap_busy", busy, 0);

      // halt while filling to full, then drain
      halt = 1'b1; host_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_entry(16 + i);
         tick();
      end
      check("full_count", count, 8);
      check("full_ready", host_ready, 0);
      set_entry(24);
      tick();
      check("full_count9", count, 8);
      check("full_instv", instv, 0);
      host_valid = 1'b0; halt = 1'b0;
      tick();
      check("drain_first", instv, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_issue($sformatf("drain%0d", i), 16 + i);
      end
      tick();
      check("drain_instv", instv, 0);
      check("drain_count", count, 0);

      // machine-reset pulse with two buffered entries
      halt = 1'b1; host_valid = 1'b1;
      set_entry(32); tick();
      set_entry(33); tick();
      host_valid = 1'b0; halt = 1'b0; mc_rst_req = 1'b1;
      tick();
      mc_rst_req = 1'b0;
      check("mcr_pulse0", mc_reset, 1);
      check("mcr_instv0", instv, 0);
      tick();
      check("mcr_pulse1", mc_reset, 1);
      check("mcr_instv1", instv, 0);
      tick();
      check("mcr_end", mc_reset, 0);
      check("mcr_count", count, 2);
      tick();
      check("mcr_instv3", instv, 0);
      tick();
      check_issue("mcr_x", 32);
      tick();
      check_issue("mcr_y", 33);
      check("mcr_count0", count, 0);
      tick();

      // reset request coinciding with an issue pop drops that entry
      halt = 1'b1; host_valid = 1'b1;
      set_entry(40); tick();
      set_entry(41); tick();
      host_valid = 1'b0; halt = 1'b0;
      tick();
      mc_rst_req = 1'b1;
      tick();
      mc_rst_req = 1'b0;
      check("cancel_instv", instv, 0);
      check("cancel_hold", opcode, 33);
      check("cancel_count", count, 1);
      check("cancel_mcr", mc_reset, 1);
      repeat (3) tick();
      tick();
      check_issue("cancel_next", 41);
      tick();

      // simultaneous push and pop at count 4, then async reset mid-stream
      halt = 1'b1; host_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_entry(48 + i);
         tick();
      end
      set_entry(51); halt = 1'b0;
      tick();
      check("pp_count4", count, 4);
      set_entry(52);
      tick();
      check("pp_count_a", count, 4);
      check_issue("pp_a", 48);
      set_entry(53);
      tick();
      check("pp_count_b", count, 4);
      check_issue("pp_b", 49);
      host_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("arst_instv", instv, 0);
      check("arst_count", count, 0);
      check("arst_ready", host_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_op", opcode, 0);
      tick();
      reset = 1'b1;
      repeat (4) tick();
      check("post_count", count, 0);
      check("post_instv", instv, 0);
      check("post_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_issuer.md
INST_ISSUER -- requirements
Module: inst_issuer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 8, instruction buffer entries (power of 2, at least 2); RST_CYCLES, default 2, machine-reset pulse length in cycles (at least 1); GAP_W, default 4, width of the gap port.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low block reset.
REQ-005 host_valid  input  1  host offers an instruction.
REQ-006 host_ready  output  1  buffer can accept an instruction.
REQ-007 host_opcode/host_imm/host_src1/host_src2/host_dst  input  t_opcode/t_data/t_reg_name x3  offered instruction fields.
REQ-008 gap  input  GAP_W  idle cycles inserted after each issued instruction; sampled at issue.
REQ-009 halt  input  1  suspends issue while high; the buffer keeps accepting.
REQ-010 mc_rst_req  input  1  requests a machine-reset pulse.
REQ-011 mc_reset  output  1  machine reset, active-high, drives the machine's reset input.
REQ-012 instv/opcode/imm/src1/src2/dst  output  1/t_opcode/t_data/t_reg_name x3  machine instruction bus, all registered.
REQ-013 count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-014 busy  output  1  high when the state is not IDLE or count is not 0.

Function
REQ-015 A push SHALL occur on each rising edge where host_valid and host_ready are both high; host_ready SHALL equal !full, with no combinational path from host_valid.
REQ-016 A push while full SHALL be impossible, and the buffer SHALL never overwrite an entry.
REQ-017 On a simultaneous push and pop, count SHALL be unchanged and the data SHALL remain in FIFO order.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, GAP and RSTP.
REQ-019 IDLE -> ISSUE when count > 0, halt = 0 and mc_reset = 0.
REQ-020 In ISSUE the block SHALL pop the head entry, and the next cycle SHALL show instv = 1 with that entry's fields, for exactly one cycle.
REQ-021 After an issue the FSM SHALL go to GAP when the sampled gap > 0, otherwise to ISSUE if the issue conditions still hold, else to IDLE.
REQ-022 Back-to-back issue SHALL sustain one instruction per cycle when gap = 0.
REQ-023 GAP SHALL hold instv = 0 for exactly gap cycles and then re-evaluate the issue conditions.
REQ-024 The gap counter SHALL keep counting while halt is high.
REQ-025 Latency SHALL be 2 cycles: an entry accepted into an empty buffer at edge k, with halt low, appears with instv = 1 in the cycle after edge k+2.
REQ-026 halt asserted SHALL allow no new pop from the next edge onward, and an instruction already popped SHALL still present.
REQ-027 mc_rst_req high in any state SHALL enter RSTP and drive mc_reset = 1 for RST_CYCLES cycles.
REQ-028 In RSTP, instv SHALL be forced to 0, the gap counter cleared and buffer contents retained; afterwards the FSM SHALL go to IDLE.
REQ-029 mc_rst_req during RSTP SHALL restart the pulse counter.
REQ-030 mc_rst_req coinciding with an ISSUE pop SHALL cancel that issue (instv stays 0), and the popped entry SHALL be lost.
REQ-031 While instv = 0, opcode/imm/src1/src2/dst SHALL hold the last issued values.
REQ-032 The count wrap SHALL be correct: read and write pointers wrap modulo FIFO_DEPTH, and count SHALL span 0..FIFO_DEPTH inclusive.

Reset
REQ-033 On reset low the block SHALL enter IDLE and clear the pointers, count and gap counter.
REQ-034 On reset low the outputs SHALL be: instv = 0, fields = 0, mc_reset = 0, host_ready = 1, busy = 0.
REQ-035 Reset assertion mid-operation SHALL discard all buffered entries immediately (asynchronous).
REQ-036 Reset deassertion SHALL be synchronized before it releases the state.

Structure
REQ-037 t_opcode, t_data and t_reg_name SHALL come from the shared package, and t_issue_state (IDLE, ISSUE, GAP, RSTP) SHALL be added there.
REQ-038 The buffer SHALL be the sub-module issuer_fifo (push/pop/full/empty/count), and the FSM, counters and output registers SHALL live in inst_issuer.

Verification
REQ-039 Reset, then push A, B, C with gap = 0 and halt = 0 -> instv = 1 on three consecutive cycles with A, B, C in order; the first appears 2 cycles after A is accepted.
REQ-040 gap = 3, push two entries -> instv pulses separated by exactly 3 instv = 0 cycles.
REQ-041 halt = 1, push 8 entries -> count = 8, host_ready = 0, 9th host_valid not accepted; halt = 0 -> 8 issues in order, count returns to 0.
REQ-042 mc_rst_req pulse with 2 entries buffered -> mc_reset = 1 for exactly 2 cycles, no instv; then both entries issue, count 2 -> 0.
REQ-043 Push and issue on the same edge at count = 4 -> count stays 4; assert reset low mid-stream -> instv = 0, count = 0 immediately.
